// File: rtl/router_pkg.sv
// Shared definitions for the router output-port receivers.
// Contents: default FIFO depth / byte width, receiver FSM state encoding.
package router_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        SYNC = 2'd0,   // wait for frame_n high before accepting a packet
        IDLE = 2'd1,   // between packets
        RECV = 2'd2,   // deserializing a packet
        DROP = 2'd3    // discarding the rest of a packet after an overflow
    } rx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through head and overflow-aware push acceptance.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push_i          : push request, push_data_i is the entry (data + last flag)
//   pop_i           : pop request; ignored while empty
//   head_o          : oldest entry, zero while empty
//   empty_o, full_o : occupancy flags
//   push_ready_o    : a push this cycle would be stored (not full, or a pop frees a slot)
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          push_ready_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          pop_ok, push_ok;

    assign empty_o      = (cnt_q == '0);
    assign full_o       = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok       = pop_i && !empty_o;
    assign push_ready_o = !full_o || pop_ok;
    assign push_ok      = push_i && push_ready_o;
    // Gating the head keeps rd_data at zero after reset without resetting storage.
    assign head_o       = empty_o ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data_i;
    end

endmodule

// File: rtl/port_receiver.sv
// Receiver for one router output port: deserializes framed serial bits
// (LSB first) into bytes and queues them with an end-of-packet flag.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   din, frame_n,
//   valid_n            : serial bit, active-low frame, active-low bit-valid
//   rd_en              : consumer pop request
//   rd_data, rd_last   : FIFO head byte and its end-of-packet flag
//   empty, full        : FIFO occupancy
//   ovf_err, part_err  : sticky errors (byte lost to full FIFO / partial trailing byte)
module port_receiver
    import router_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             frame_n,
    input  logic             valid_n,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             part_err
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH-1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             ovf_q, ovf_d;
    logic             part_q, part_d;
    logic [WIDTH-1:0] cap;
    logic             push, push_ready;
    logic [WIDTH:0]   head;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ovf_d    = ovf_q;
        part_d   = part_q;
        push     = 1'b0;
        // Shift register with this cycle's bit merged in; this is what gets pushed.
        cap           = shift_q;
        cap[bitcnt_q] = din;

        unique case (state_q)
            SYNC: if (frame_n) state_d = IDLE;
            IDLE: begin
                if (!frame_n) begin
                    state_d  = RECV;
                    shift_d  = '0;
                    bitcnt_d = '0;
                    if (!valid_n) begin
                        shift_d[0] = din;
                        bitcnt_d   = CW'(1);
                    end
                end
            end
            RECV: begin
                if (!valid_n) begin
                    if (bitcnt_q == LAST_BIT) begin
                        push     = 1'b1;
                        shift_d  = '0;
                        bitcnt_d = '0;
                        if (!push_ready) begin
                            ovf_d   = 1'b1;
                            state_d = frame_n ? IDLE : DROP;
                        end
                    end else begin
                        shift_d  = cap;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                // Packet end: anything left in the shift register is a partial byte.
                if (frame_n) begin
                    state_d = IDLE;
                    if (bitcnt_d != '0) begin
                        part_d   = 1'b1;
                        shift_d  = '0;
                        bitcnt_d = '0;
                    end
                end
            end
            DROP: if (frame_n) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SYNC;
            bitcnt_q <= '0;
            shift_q  <= '0;
            ovf_q    <= 1'b0;
            part_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            ovf_q    <= ovf_d;
            part_q   <= part_d;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_data_i  ({frame_n, cap}),
        .pop_i        (rd_en),
        .head_o       (head),
        .empty_o      (empty),
        .full_o       (full),
        .push_ready_o (push_ready)
    );

    assign rd_data  = head[WIDTH-1:0];
    assign rd_last  = head[WIDTH];
    assign ovf_err  = ovf_q;
    assign part_err = part_q;

endmodule

// File: tb/tb_port_receiver.sv
// Self-checking bench for port_receiver: directed scenarios plus a randomized
// run, all compared against a packet/queue level reference model.
module tb_port_receiver;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             din = 1'b0;
    logic             frame_n = 1'b1;
    logic             valid_n = 1'b1;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last, empty, full, ovf_err, part_err;
    logic [WIDTH+4:0] obs;

    int checks = 0;
    int errors = 0;

    port_receiver #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .frame_n  (frame_n),
        .valid_n  (valid_n),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .empty    (empty),
        .full     (full),
        .ovf_err  (ovf_err),
        .part_err (part_err)
    );

    assign obs = {rd_data, rd_last, empty, full, ovf_err, part_err};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: stored bytes as a queue, packet progress as a bit count.
    logic [WIDTH:0]   m_q[$];
    bit               m_synced, m_in_pkt, m_drop, m_ovf, m_part;
    int               m_nbits;
    logic [WIDTH-1:0] m_acc;

    task automatic m_reset();
        m_q.delete();
        m_synced = 0; m_in_pkt = 0; m_drop = 0; m_ovf = 0; m_part = 0;
        m_nbits = 0; m_acc = '0;
    endtask

    task automatic m_step(input logic f, input logic v, input logic d, input logic r);
        int             pre;
        bit             pop, push;
        logic [WIDTH:0] pv;
        pre  = m_q.size();
        pop  = r && (pre > 0);
        push = 0;
        pv   = '0;
        if (m_drop) begin
            if (f) m_drop = 0;
        end else if (m_in_pkt || (m_synced && !f)) begin
            if (!m_in_pkt) begin
                m_in_pkt = 1; m_nbits = 0; m_acc = '0;
            end
            if (!v) begin
                m_acc[m_nbits] = d;
                m_nbits++;
                if (m_nbits == WIDTH) begin
                    if (pre < DEPTH || pop) begin
                        push = 1; pv = {f, m_acc};
                    end else begin
                        m_ovf = 1; m_in_pkt = 0;
                        if (!f) m_drop = 1;
                    end
                    m_nbits = 0; m_acc = '0;
                end
            end
            if (f && m_in_pkt) begin
                if (m_nbits != 0) m_part = 1;
                m_in_pkt = 0; m_nbits = 0; m_acc = '0;
            end
        end else if (f) begin
            m_synced = 1;
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(pv);
    endtask

    function automatic logic [WIDTH+4:0] m_exp();
        logic [WIDTH:0] h;
        logic           e, fl;
        h  = (m_q.size() > 0) ? m_q[0] : '0;
        e  = (m_q.size() == 0);
        fl = (m_q.size() == DEPTH);
        return {h[WIDTH-1:0], h[WIDTH], e, fl, m_ovf, m_part};
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input logic f, input logic v, input logic d, input logic r);
        frame_n = f; valid_n = v; din = d; rd_en = r;
        @(posedge clk);
        m_step(f, v, d, r);
        #1;
    endtask

    task automatic do_reset(input logic f);
        frame_n = f; valid_n = 1'b1; rd_en = 1'b0;
        reset = 1'b1;
        m_reset();
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Sends n bits LSB first; frame_n rises on the last bit. Random valid gaps.
    task automatic send_bits(input logic [63:0] bits, input int n, input int gap_pct,
                             input logic rd_on_last);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && ($urandom_range(99) < gap_pct); g++)
                cyc(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
            cyc(i == n-1, 1'b0, bits[i], (i == n-1) && rd_on_last);
        end
    endtask

    task automatic test_reset();
        logic [WIDTH+4:0] want;
        want = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        frame_n = 1'b0; valid_n = 1'b1; rd_en = 1'b0;
        reset = 1'b1;
        m_reset();
        #2;
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, want);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] w;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        w = 64'h4D;
        send_bits(w, 8, 0, 1'b0);
        checks++;
        if (rd_data !== 8'h4D) begin errors++; $display("FAIL basic_data: got %h want 4d", rd_data); end
        checks++;
        if (rd_last !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL basic_flags: last=%b empty=%b want 1 0", rd_last, empty);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL basic_pop: empty=%b want 1", empty); end
        // Pop while empty must be harmless; next byte reads back cleanly.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        w = 64'($urandom_range(255));
        send_bits(w, 8, 30, 1'b0);
        checks++;
        if (rd_data !== w[7:0] || empty !== 1'b0 || obs !== m_exp()) begin
            errors++; $display("FAIL empty_pop_ignored: got %h want %h", obs, m_exp());
        end
    endtask

    task automatic test_gaps();
        logic [63:0] w;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        w = 64'($urandom_range(65535));
        send_bits(w, 16, 50, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_data !== w[7:0] || rd_last !== 1'b0) begin
            errors++; $display("FAIL gaps_first: got %h/%b want %h/0", rd_data, rd_last, w[7:0]);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (rd_data !== w[15:8] || rd_last !== 1'b1) begin
            errors++; $display("FAIL gaps_second: got %h/%b want %h/1", rd_data, rd_last, w[15:8]);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] w, b;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        w = {24'h0, 8'($urandom_range(255)), 32'($urandom)};
        send_bits(w, 40, 20, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_flags: full=%b ovf=%b want 1 1", full, ovf_err);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_data !== w[8*k +: 8] || rd_last !== 1'b0) begin
                errors++; $display("FAIL ovf_byte%0d: got %h/%b want %h/0", k, rd_data, rd_last, w[8*k +: 8]);
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL ovf_fifth_absent: empty=%b want 1", empty); end
        b = 64'($urandom_range(255));
        send_bits(b, 8, 20, 1'b0);
        checks++;
        if (rd_data !== b[7:0] || rd_last !== 1'b1 || ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_recover: got %h/%b ovf=%b want %h/1 ovf=1", rd_data, rd_last, ovf_err, b[7:0]);
        end
    endtask

    task automatic test_partial();
        logic [63:0] w, b;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        w = 64'($urandom_range(2047));
        send_bits(w, 11, 20, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_data !== w[7:0] || rd_last !== 1'b0 || part_err !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL partial: got %h/%b part=%b want %h/0 part=1", rd_data, rd_last, part_err, w[7:0]);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        b = 64'($urandom_range(255));
        send_bits(b, 8, 20, 1'b0);
        checks++;
        if (rd_data !== b[7:0] || rd_last !== 1'b1 || part_err !== 1'b1 || obs !== m_exp()) begin
            errors++; $display("FAIL partial_next: got %h want %h", obs, m_exp());
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] b;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        send_bits(64'hFF, 8, 0, 1'b0);          // leave a stored byte behind
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
        frame_n = 1'b0;
        reset = 1'b1;
        m_reset();
        #2;
        checks++;
        if (empty !== 1'b1 || rd_data !== 8'h00) begin
            errors++; $display("FAIL reset_mid_async: empty=%b data=%h want 1 00", empty, rd_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
            checks++;
            if (empty !== 1'b1) begin errors++; $display("FAIL reset_mid_nocap%0d: empty=%b want 1", i, empty); end
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        b = 64'($urandom_range(255));
        send_bits(b, 8, 0, 1'b0);
        checks++;
        if (rd_data !== b[7:0] || rd_last !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL reset_mid_resume: got %h/%b want %h/1", rd_data, rd_last, b[7:0]);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] w;
        do_reset(1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        w = {24'h0, 8'($urandom_range(255)), 32'($urandom)};
        send_bits(w, 40, 0, 1'b1);
        checks++;
        if (full !== 1'b1 || ovf_err !== 1'b0 || rd_data !== w[15:8] || rd_last !== 1'b0) begin
            errors++; $display("FAIL full_push_pop: full=%b ovf=%b head=%h want 1 0 %h", full, ovf_err, rd_data, w[15:8]);
        end
        for (int k = 2; k < 5; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (rd_data !== w[8*k +: 8] || rd_last !== (k == 4)) begin
                errors++; $display("FAIL full_push_pop_drain%0d: got %h/%b want %h/%b", k, rd_data, rd_last, w[8*k +: 8], k == 4);
            end
        end
    endtask

    task automatic test_random();
        logic f, v, r;
        do_reset(1'b1);
        for (int i = 0; i < 800; i++) begin
            if (i < 400) begin
                f = ($urandom_range(19) == 0);
                r = ($urandom_range(15) == 0);
            end else begin
                f = ($urandom_range(5) == 0);
                r = ($urandom_range(1) == 0);
            end
            v = ($urandom_range(3) == 0);
            cyc(f, v, 1'($urandom_range(1)), r);
            checks++;
            if (obs !== m_exp()) begin
                errors++; $display("FAIL random_cyc%0d: got %h want %h", i, obs, m_exp());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_partial();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
